// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register busy scoreboard.
// Define REGFILE_WRITE_CNT_EN to add the wr_count_o effective-write counter.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              busy1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              busy2_o,
  input  logic              mark_i,
  input  logic [ADDR_W-1:0] mark_addr_i,
`ifdef REGFILE_WRITE_CNT_EN
  output logic [31:0]       wr_count_o,
`endif
  input  logic              flush_i
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic              wr_eff;
  logic              mark_eff;

  assign wr_eff   = we_i && (waddr_i != '0);
  assign mark_eff = mark_i && (mark_addr_i != '0);

  // x0 is never written, so clearing it on reset keeps it hardwired to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  // Clear then mark: a same-cycle mark of the retiring index belongs to a newer writer.
  always_comb begin
    busy_next = busy;
    if (wr_eff) begin
      busy_next[waddr_i] = 1'b0;
    end
    if (mark_eff) begin
      busy_next[mark_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  function automatic logic [DATA_W-1:0] read_data(input logic re,
                                                  input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] d;
    d = '0;
    if (!rst && re && (ra != '0)) begin
      if (we_i && (waddr_i == ra)) begin
        d = wdata_i;
      end else begin
        d = regs[ra];
      end
    end
    return d;
  endfunction

  function automatic logic read_busy(input logic re, input logic [ADDR_W-1:0] ra);
    return !rst && re && (ra != '0) && busy[ra] && !(we_i && (waddr_i == ra));
  endfunction

  always_comb begin
    rdata1_o = read_data(re1_i, raddr1_i);
    rdata2_o = read_data(re2_i, raddr2_i);
    busy1_o  = read_busy(re1_i, raddr1_i);
    busy2_o  = read_busy(re2_i, raddr2_i);
  end

`ifdef REGFILE_WRITE_CNT_EN
  logic [31:0] wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (wr_eff) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  assign wr_count_o = wr_count;
`endif

endmodule
